// File: rtl/rose_arb_pkg.sv
// Shared types and range limits for the rising-edge event arbiter.
package rose_arb_pkg;

    // Grant FSM: waiting for a pending event, or holding an offered grant.
    typedef enum logic {
        IDLE,
        OFFER
    } arb_state_t;

    // Legal range for the number of request lines.
    localparam int unsigned N_REQ_MIN = 2;
    localparam int unsigned N_REQ_MAX = 16;

endpackage : rose_arb_pkg

// File: rtl/rose_detect.sv
// Per-bit rising-edge detector: compares each input bit against its value
// from the previous posedge, matching $rose sampled-edge semantics.
module rose_detect #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sig_i,
    output logic [W-1:0] rose_o
);

    logic [W-1:0] prev_q;

    // Remember last sampled value; reset to 0 so a line already high counts as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rose_o = sig_i & ~prev_q;

endmodule : rose_detect

// File: rtl/rose_event_arbiter.sv
// Collects rising-edge events on N_REQ request lines, holds one pending event
// per line, flags lost events, and grants pending lines round-robin over a
// valid/ready handshake.
module rose_event_arbiter
    import rose_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output logic             gnt_valid_o,
    output logic [IDW-1:0]   gnt_id_o,
    input  logic             gnt_ready_i,
    output logic [N_REQ-1:0] pend_o,
    output logic [N_REQ-1:0] ovf_o,
    input  logic             ovf_clr_i
);

    if ((N_REQ < N_REQ_MIN) || (N_REQ > N_REQ_MAX)) begin : g_bad_n_req
        $error("rose_event_arbiter: N_REQ out of range");
    end

    // Round-robin pick: rotate the pending vector so index ptr+1 lands at
    // bit 0, take the lowest set bit, then map back to the original index.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] pend,
                                               input logic [IDW-1:0]   ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        int unsigned        start;
        int unsigned        idx;
        logic               found;
        start   = 32'(ptr) + 32'd1;
        dbl     = {pend, pend} >> start;
        rot     = dbl[N_REQ-1:0];
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                idx = start + i;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                rr_pick = IDW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    arb_state_t       state_q, state_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [N_REQ-1:0] ovf_q, ovf_d;
    logic [N_REQ-1:0] rose;
    logic [N_REQ-1:0] clr;
    logic             hs;

    rose_detect #(
        .W (N_REQ)
    ) u_rose_detect (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (req_i),
        .rose_o (rose)
    );

    // FSM state, grant id and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_id_q <= '0;
            ptr_q    <= IDW'(N_REQ - 1);
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
        end
    end

    // Next-state: arbitrate only from IDLE; hold the grant until accepted.
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        hs       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    gnt_id_d = rr_pick(pend_q, ptr_q);
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (gnt_ready_i) begin
                    hs      = 1'b1;
                    ptr_d   = gnt_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending and overflow update; a rise on the line being cleared re-arms it
    // without counting as a lost event.
    always_comb begin
        clr = '0;
        if (hs) begin
            clr[gnt_id_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | rose;
        ovf_d  = ovf_clr_i ? '0 : ovf_q;
        ovf_d  = ovf_d | (rose & pend_q & ~clr);
    end

    // Pending-event and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign gnt_valid_o = (state_q == OFFER);
    assign gnt_id_o    = gnt_id_q;
    assign pend_o      = pend_q;
    assign ovf_o       = ovf_q;

endmodule : rose_event_arbiter

// File: tb/tb_rose_event_arbiter.sv
// Self-checking bench for rose_event_arbiter: a cycle-level reference model
// checked every cycle, plus directed scenarios with hand-computed values.
module tb_rose_event_arbiter;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_i;
    logic         gnt_valid_o;
    logic [1:0]   gnt_id_o;
    logic         gnt_ready_i;
    logic [N-1:0] pend_o;
    logic [N-1:0] ovf_o;
    logic         ovf_clr_i;

    int total = 0;
    int bad   = 0;

    rose_event_arbiter #(
        .N_REQ (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .gnt_valid_o (gnt_valid_o),
        .gnt_id_o    (gnt_id_o),
        .gnt_ready_i (gnt_ready_i),
        .pend_o      (pend_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one pending flag per line, a grant slot, a last-served
    // index, and a log of every accepted grant.
    bit [N-1:0]  m_prev, m_pend, m_ovf, m_rose, m_clr, m_old;
    bit          m_valid, m_hs, m_found;
    int unsigned m_id, m_last, m_j;
    int unsigned grants[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev  = '0;
            m_pend  = '0;
            m_ovf   = '0;
            m_valid = 1'b0;
            m_id    = 0;
            m_last  = N - 1;
        end else begin
            m_hs   = m_valid && gnt_ready_i;
            m_old  = m_pend;
            m_rose = req_i & ~m_prev;
            m_prev = req_i;
            m_clr  = '0;
            if (m_hs) m_clr[m_id] = 1'b1;
            if (ovf_clr_i) m_ovf = '0;
            m_ovf  = m_ovf | (m_rose & m_old & ~m_clr);
            m_pend = (m_old & ~m_clr) | m_rose;
            if (m_hs) begin
                grants.push_back(m_id);
                m_last  = m_id;
                m_valid = 1'b0;
            end else if (!m_valid && m_old != '0) begin
                m_found = 1'b0;
                for (int unsigned k = 1; k <= N; k++) begin
                    m_j = (m_last + k) % N;
                    if (!m_found && m_old[m_j]) begin
                        m_id    = m_j;
                        m_valid = 1'b1;
                        m_found = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(posedge clk) begin
        #1;
        check("model_valid", 32'(gnt_valid_o), 32'(m_valid));
        if (m_valid) check("model_id", 32'(gnt_id_o), m_id);
        check("model_pend", 32'(pend_o), 32'(m_pend));
        check("model_ovf", 32'(ovf_o), 32'(m_ovf));
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_i       = '0;
        gnt_ready_i = 1'b0;
        ovf_clr_i   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        rst_n       = 1'b0;
        req_i       = '0;
        gnt_ready_i = 1'b0;
        ovf_clr_i   = 1'b0;
        step(2);
        check("rst_valid", 32'(gnt_valid_o), 32'd0);
        check("rst_id", 32'(gnt_id_o), 32'd0);
        check("rst_pend", 32'(pend_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Single event on line 2, held high three cycles.
        base        = grants.size();
        req_i       = 4'b0100;
        gnt_ready_i = 1'b1;
        step();
        check("single_pend_k", 32'(pend_o), 32'h4);
        check("single_valid_k", 32'(gnt_valid_o), 32'd0);
        step();
        check("single_valid_k1", 32'(gnt_valid_o), 32'd1);
        check("single_id_k1", 32'(gnt_id_o), 32'd2);
        step();
        check("single_valid_k2", 32'(gnt_valid_o), 32'd0);
        check("single_pend_k2", 32'(pend_o), 32'd0);
        req_i = '0;
        step(3);
        check("single_count", 32'(grants.size() - base), 32'd1);

        // Round-robin from reset: all four lines rise together.
        do_reset();
        base        = grants.size();
        req_i       = 4'b1111;
        gnt_ready_i = 1'b1;
        step();
        check("rr_pend_k", 32'(pend_o), 32'hf);
        step();
        check("rr_id0", 32'(gnt_id_o), 32'd0);
        step(2);
        check("rr_id1", 32'(gnt_id_o), 32'd1);
        step(2);
        check("rr_id2", 32'(gnt_id_o), 32'd2);
        step(2);
        check("rr_id3", 32'(gnt_id_o), 32'd3);
        step(2);
        check("rr_pend_end", 32'(pend_o), 32'd0);
        check("rr_count", 32'(grants.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (grants.size() > base + i)
                check("rr_order", grants[base + i], i);
        end
        req_i = '0;

        // Backpressure on id 1 while line 3 rises.
        do_reset();
        req_i       = 4'b0010;
        gnt_ready_i = 1'b0;
        step(2);
        check("bp_valid", 32'(gnt_valid_o), 32'd1);
        check("bp_id", 32'(gnt_id_o), 32'd1);
        req_i = 4'b1010;
        step();
        check("bp_pend3", 32'(pend_o), 32'ha);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_id", 32'(gnt_id_o), 32'd1);
            check("bp_hold_valid", 32'(gnt_valid_o), 32'd1);
        end
        gnt_ready_i = 1'b1;
        step();
        check("bp_hs_valid", 32'(gnt_valid_o), 32'd0);
        check("bp_hs_pend", 32'(pend_o), 32'h8);
        step();
        check("bp_id3_valid", 32'(gnt_valid_o), 32'd1);
        check("bp_id3", 32'(gnt_id_o), 32'd3);
        step();
        check("bp_end_pend", 32'(pend_o), 32'd0);
        req_i = '0;

        // Overflow on line 0 while its grant is stalled.
        do_reset();
        gnt_ready_i = 1'b0;
        req_i       = 4'b0001;
        step(2);
        check("ovf_offer_id", 32'(gnt_id_o), 32'd0);
        req_i = '0;
        step();
        check("ovf_none_yet", 32'(ovf_o), 32'd0);
        req_i = 4'b0001;
        step();
        check("ovf_set", 32'(ovf_o), 32'h1);
        req_i = '0;
        step();
        check("ovf_sticky", 32'(ovf_o), 32'h1);
        ovf_clr_i = 1'b1;
        step();
        ovf_clr_i = 1'b0;
        check("ovf_cleared", 32'(ovf_o), 32'd0);
        req_i     = 4'b0001;
        ovf_clr_i = 1'b1;
        step();
        check("ovf_clr_vs_rose", 32'(ovf_o), 32'h1);
        ovf_clr_i   = 1'b0;
        req_i       = '0;
        gnt_ready_i = 1'b1;
        step(2);

        // Handshake on id 2 coinciding with a new rise on line 2.
        do_reset();
        gnt_ready_i = 1'b0;
        req_i       = 4'b0100;
        step(2);
        check("sim_offer_id", 32'(gnt_id_o), 32'd2);
        req_i = '0;
        step();
        req_i       = 4'b0100;
        gnt_ready_i = 1'b1;
        step();
        check("sim_pend", 32'(pend_o), 32'h4);
        check("sim_ovf", 32'(ovf_o), 32'd0);
        check("sim_valid_drop", 32'(gnt_valid_o), 32'd0);
        step();
        check("sim_regrant_valid", 32'(gnt_valid_o), 32'd1);
        check("sim_regrant_id", 32'(gnt_id_o), 32'd2);
        step();
        req_i       = '0;
        gnt_ready_i = 1'b0;

        // Reset asserted while offering with several lines pending.
        do_reset();
        req_i = 4'b1011;
        step(2);
        check("mid_pend", 32'(pend_o), 32'hb);
        check("mid_valid", 32'(gnt_valid_o), 32'd1);
        rst_n = 1'b0;
        req_i = 4'b0001;
        #1;
        check("mid_rst_valid", 32'(gnt_valid_o), 32'd0);
        check("mid_rst_id", 32'(gnt_id_o), 32'd0);
        check("mid_rst_pend", 32'(pend_o), 32'd0);
        check("mid_rst_ovf", 32'(ovf_o), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("mid_first_rose", 32'(pend_o), 32'h1);
        step();
        check("mid_grant_valid", 32'(gnt_valid_o), 32'd1);
        check("mid_grant_id", 32'(gnt_id_o), 32'd0);
        gnt_ready_i = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rose_event_arbiter

// File: doc/rose_event_arbiter.md
# rose_event_arbiter

Collects rising-edge events from N_REQ single-bit request lines, using the same sampled-edge semantics as `$rose`. It holds one pending event per line and grants them one at a time to a shared downstream consumer in round-robin order, over a valid/ready handshake. It sits between asynchronous-to-logic status strobes (already synchronised to `clk`) and a single event-processing resource. It also flags events that are lost because their line already had an event pending.

## Interface
- `N_REQ`, 4, number of request lines (2..16)
- `IDW`, `$clog2(N_REQ)`, width of grant index (derived, not overridden)

- `clk`  in  1  clock; all sampling on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_i`  in  N_REQ  level request lines, sampled each posedge
- `gnt_valid_o`  out  1  grant offered to consumer
- `gnt_id_o`  out  IDW  index of granted line; valid while `gnt_valid_o`=1
- `gnt_ready_i`  in  1  consumer accepts the grant
- `pend_o`  out  N_REQ  pending-event bit per line
- `ovf_o`  out  N_REQ  sticky lost-event flag per line
- `ovf_clr_i`  in  1  clears all `ovf_o` bits

## Operation
- Edge detect: `prev[i]` holds `req_i[i]` from the previous posedge.
  - `rose[i] = req_i[i] & ~prev[i]` at each posedge.
  - `prev` resets to 0, so a line high at the first edge after reset counts as a rose.
- Pending: `rose[i]` sets `pend[i]`. A handshake on id i clears `pend[i]`. If a handshake clears `pend[i]` and `rose[i]` occurs on the same edge, `pend[i]` stays 1 and no overflow is raised.
- Overflow: `rose[i]` while `pend[i]`=1 and not being cleared that edge sets `ovf[i]`. `ovf_clr_i` clears all bits. If clear and a new overflow hit the same edge, the new overflow wins for that bit.
- FSM, 2 states:
  - IDLE: `gnt_valid_o`=0. If any `pend` bit is set, pick the first set index scanning from `ptr+1` upward, wrapping modulo N_REQ. Register it into `gnt_id_o`, set `gnt_valid_o`=1, go to OFFER.
  - OFFER: `gnt_id_o` and `gnt_valid_o` are held stable, and no new arbitration happens. On `gnt_valid_o & gnt_ready_i` at a posedge: clear `pend[gnt_id_o]`, set `ptr<=gnt_id_o`, drop `gnt_valid_o`, go to IDLE.
- Events arriving during OFFER only set `pend`/`ovf`; they never alter the current grant.
- `ptr` resets to N_REQ-1, so index 0 has first priority after reset.

## Timing
- Reset values: `gnt_valid_o`=0, `gnt_id_o`=0, `pend_o`=0, `ovf_o`=0. Internally, state=IDLE, `prev`=0, `ptr`=N_REQ-1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: a rose sampled at posedge k sets `pend_o` after edge k. With the FSM in IDLE, `gnt_valid_o` rises after edge k+1.
- Throughput: at most one grant per 2 cycles, because the handshake edge returns the FSM to IDLE and the next grant is issued on the following edge.
- `gnt_ready_i` is ignored while `gnt_valid_o`=0.
- Reset asserted mid-OFFER: `gnt_valid_o` drops immediately (asynchronously) and all pending events are discarded.

## Structure
- Package `rose_arb_pkg`: `typedef enum logic {IDLE, OFFER} arb_state_t`, plus the `N_REQ` min/max range constants.
- Sub-module `rose_detect`: per-vector edge detector with a `prev` register and `rose` output, parameterised by width and instantiated once.
- Round-robin pick: a combinational function in the top module, done as a double-width rotate plus priority scan.

## Test plan
- **Single event:** reset, then `req_i`=4'b0100 held 3 cycles, `gnt_ready_i`=1.
  - `pend_o[2]` is set after edge k.
  - `gnt_valid_o`=1 with `gnt_id_o`=2 after edge k+1.
  - Cleared after edge k+2.
  - Exactly one grant; a held-high level produces no further events.
- **Round-robin:** `req_i` goes 0→4'b1111 in one cycle, `gnt_ready_i`=1. Grant order is 0,1,2,3, one grant every 2 cycles, and `pend_o` ends at 0.
- **Backpressure:** grant id 1 offered, `gnt_ready_i`=0 for 5 cycles.
  - `gnt_id_o` stays 1 and `gnt_valid_o` stays 1.
  - A rose on line 3 meanwhile sets `pend_o[3]` only.
  - Id 3 is granted 2 cycles after `gnt_ready_i` rises.
- **Overflow:** line 0 pending and not granted (`gnt_ready_i`=0), then pulse `req_i[0]` 0→1→0→1.
  - `ovf_o[0]`=1 and is sticky.
  - `ovf_clr_i` pulse clears it.
  - Clear coinciding with a new rose leaves `ovf_o[0]`=1.
- **Simultaneous clear and rose:** handshake on id 2 on the same edge as a new rose on line 2. `pend_o[2]` stays 1, `ovf_o[2]` stays 0, and id 2 is re-granted.
- **Reset mid-operation:** drive `rst_n`=0 during OFFER with `pend_o`=4'b1011.
  - All outputs are 0 immediately.
  - After release, with `req_i` held at 4'b0001, id 0 is granted as a first-edge rose.
